// File: rtl/iterative_circular_rotator_if.sv
// Valid/ready handshake bundle for the iterative circular rotator.
// The slave modport is the rotator side; the master modport is the side that drives it.
interface iterative_circular_rotator_if #(
    parameter int N = 8
);
    localparam int SW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [SW-1:0] in_shift;
    logic          in_dir;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          busy;

    modport slave (
        input  in_valid, in_data, in_shift, in_dir, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_shift, in_dir, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/iterative_circular_rotator.sv
// Multi-cycle circular shifter: rotates one word by one bit per clock, then holds
// the result until the downstream side takes it.
module iterative_circular_rotator #(
    parameter int N = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    iterative_circular_rotator_if.slave    bus
);
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [SW-1:0] count_q, count_d;
    logic          dir_q, dir_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        dir_d   = dir_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    count_d = bus.in_shift;
                    dir_d   = bus.in_dir;
                    state_d = (bus.in_shift == '0) ? DONE : ROTATE;
                end
            end
            ROTATE: begin
                data_d  = dir_q ? {data_q[0], data_q[N-1:1]} : {data_q[N-2:0], data_q[N-1]};
                count_d = count_q - SW'(1);
                if (count_q == SW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered alongside it.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            count_q     <= '0;
            dir_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = busy_q;
endmodule
